// File: rtl/vx_mem_responder.sv
// -----------------------------------------------------------------------------
// vx_mem_responder
//
// Responder end of the Vortex memory bus. Serves read and write requests from
// an internal word-addressed array. Writes are byte-masked and silent. Reads
// return {data, tag} in request order after LATENCY cycles, through a response
// FIFO. A credit counter keeps the FIFO from ever overflowing.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. The sender holds its payload stable
// while valid is high and ready is low.
//
// Parameters
//   DATA_SIZE       word size in bytes
//   ADDR_WIDTH      word address width (depth = 2^ADDR_WIDTH words)
//   TAG_WIDTH       request/response tag width
//   FLAGS_WIDTH     request flags width (flags are ignored)
//   LATENCY         cycles from read acceptance to earliest rsp_valid (>= 1)
//   RSP_QUEUE_SIZE  max outstanding reads, power of 2, >= 2
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   mem_req_*           request channel (valid/ready, rw, addr, data,
//                       byteen, flags, tag)
//   mem_rsp_*           read response channel (valid/ready, data, tag)
//   pending_reads       reads accepted but not yet handed back
// -----------------------------------------------------------------------------
module vx_mem_responder #(
    parameter int DATA_SIZE      = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int TAG_WIDTH      = 8,
    parameter int FLAGS_WIDTH    = 1,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,

    input  logic                                  mem_req_valid,
    input  logic                                  mem_req_rw,
    input  logic [ADDR_WIDTH-1:0]                 mem_req_addr,
    input  logic [DATA_SIZE*8-1:0]                mem_req_data,
    input  logic [DATA_SIZE-1:0]                  mem_req_byteen,
    input  logic [FLAGS_WIDTH-1:0]                mem_req_flags,
    input  logic [TAG_WIDTH-1:0]                  mem_req_tag,
    output logic                                  mem_req_ready,

    output logic                                  mem_rsp_valid,
    output logic [DATA_SIZE*8-1:0]                mem_rsp_data,
    output logic [TAG_WIDTH-1:0]                  mem_rsp_tag,
    input  logic                                  mem_rsp_ready,

    output logic [$clog2(RSP_QUEUE_SIZE+1)-1:0]   pending_reads
);

    localparam int DATA_W  = DATA_SIZE * 8;
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int ENTRY_W = DATA_W + TAG_WIDTH;
    localparam int PTR_W   = $clog2(RSP_QUEUE_SIZE);
    localparam int CNT_W   = $clog2(RSP_QUEUE_SIZE + 1);

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RSP_QUEUE_SIZE);

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic req_fire;
    logic wr_fire;
    logic rd_fire;
    logic rsp_fire;

    assign req_fire = mem_req_valid & mem_req_ready;
    assign wr_fire  = req_fire &  mem_req_rw;
    assign rd_fire  = req_fire & ~mem_req_rw;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    // Flags carry no meaning for this responder.
    logic unused_flags;
    assign unused_flags = ^mem_req_flags;

    // -------------------------------------------------------------------------
    // Storage array. No reset: contents survive reset_n.
    // A write lands on the clock edge, so a read firing in the next cycle
    // already sees it through the combinational read port below.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                if (mem_req_byteen[i]) begin
                    mem[mem_req_addr][i*8 +: 8] <= mem_req_data[i*8 +: 8];
                end
            end
        end
    end

    logic [ENTRY_W-1:0] rd_entry;
    assign rd_entry = {mem[mem_req_addr], mem_req_tag};

    // -------------------------------------------------------------------------
    // Read latency pipeline.
    // The fire cycle itself counts as the first latency cycle, so only
    // LATENCY-1 register stages sit in front of the FIFO. The last stage
    // writes the FIFO on its edge, making rsp_valid visible exactly LATENCY
    // cycles after the fire.
    // -------------------------------------------------------------------------
    logic               push_valid;
    logic [ENTRY_W-1:0] push_entry;

    generate
        if (LATENCY > 1) begin : g_pipe
            localparam int STAGES = LATENCY - 1;

            logic [STAGES-1:0]  stage_valid;
            logic [ENTRY_W-1:0] stage_entry [STAGES];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_valid <= '0;
                end else begin
                    stage_valid[0] <= rd_fire;
                    for (int k = 1; k < STAGES; k++) begin
                        stage_valid[k] <= stage_valid[k-1];
                    end
                end
            end

            // Payload needs no reset; the valid bits qualify it.
            always_ff @(posedge clk) begin
                stage_entry[0] <= rd_entry;
                for (int k = 1; k < STAGES; k++) begin
                    stage_entry[k] <= stage_entry[k-1];
                end
            end

            assign push_valid = stage_valid[STAGES-1];
            assign push_entry = stage_entry[STAGES-1];
        end else begin : g_direct
            assign push_valid = rd_fire;
            assign push_entry = rd_entry;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Response FIFO. Pointers wrap naturally because the depth is a power
    // of two; the occupancy count disambiguates full from empty.
    // Overflow cannot happen: every entry in the pipeline or FIFO holds a
    // credit, and credits are capped at RSP_QUEUE_SIZE.
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [RSP_QUEUE_SIZE];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_valid) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rsp_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_valid, rsp_fire})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_valid) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // -------------------------------------------------------------------------
    // Read credit counter: +1 on read fire, -1 on response handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reads <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   pending_reads <= pending_reads + CNT_W'(1);
                2'b01:   pending_reads <= pending_reads - CNT_W'(1);
                default: pending_reads <= pending_reads;
            endcase
        end
    end

    // Ready comes purely from registered credit state, so it never depends
    // on the request's own valid or rw in the same cycle.
    assign mem_req_ready = (pending_reads < CREDIT_MAX);

    // -------------------------------------------------------------------------
    // Response outputs. The head is forced to zero while the FIFO is empty so
    // the data/tag outputs read 0 straight out of reset (the FIFO storage
    // itself is not reset).
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] head_entry;

    assign head_entry    = fifo_mem[rd_ptr];
    assign mem_rsp_valid = (fifo_count != '0);
    assign mem_rsp_data  = mem_rsp_valid ? head_entry[ENTRY_W-1:TAG_WIDTH] : '0;
    assign mem_rsp_tag   = mem_rsp_valid ? head_entry[TAG_WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_vx_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_vx_mem_responder
//
// Self-checking bench for vx_mem_responder (DATA_SIZE=4, ADDR_WIDTH=4,
// LATENCY=2, RSP_QUEUE_SIZE=4). A bench-side memory model computes read data;
// expected {data, tag} is queued when a read fires and compared when the DUT
// hands back a response.
// -----------------------------------------------------------------------------
module tb_vx_mem_responder;

  localparam int DATA_SIZE   = 4;
  localparam int ADDR_WIDTH  = 4;
  localparam int TAG_WIDTH   = 8;
  localparam int FLAGS_WIDTH = 1;
  localparam int LATENCY     = 2;
  localparam int QSIZE       = 4;
  localparam int PW          = $clog2(QSIZE + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                   mem_req_valid;
  logic                   mem_req_rw;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic [31:0]            mem_req_data;
  logic [3:0]             mem_req_byteen;
  logic [FLAGS_WIDTH-1:0] mem_req_flags;
  logic [TAG_WIDTH-1:0]   mem_req_tag;
  logic                   mem_req_ready;
  logic                   mem_rsp_valid;
  logic [31:0]            mem_rsp_data;
  logic [TAG_WIDTH-1:0]   mem_rsp_tag;
  logic                   mem_rsp_ready;
  logic [PW-1:0]          pending_reads;

  vx_mem_responder #(
    .DATA_SIZE      (DATA_SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .TAG_WIDTH      (TAG_WIDTH),
    .FLAGS_WIDTH    (FLAGS_WIDTH),
    .LATENCY        (LATENCY),
    .RSP_QUEUE_SIZE (QSIZE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_flags  (mem_req_flags),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .pending_reads  (pending_reads)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rsp_count = 0;
  logic [39:0] exp_q[$];
  logic [39:0] sb_e;
  logic [31:0] model [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every response handshake against the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && mem_rsp_valid && mem_rsp_ready) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", 64'(mem_rsp_valid), 64'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check_eq("rsp_data", 64'(mem_rsp_data), 64'(sb_e[39:8]));
        check_eq("rsp_tag",  64'(mem_rsp_tag),  64'(sb_e[7:0]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic rw, input logic [3:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [7:0] tag);
    int   waited = 0;
    logic fired  = 1'b0;
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_data   = data;
    mem_req_byteen = be;
    mem_req_tag    = tag;
    while (!fired) begin
      @(negedge clk);
      if (mem_req_ready) begin
        fired = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          check_eq("req_timeout", 64'(mem_req_ready), 64'd1);
          break;
        end
      end
    end
    if (fired) begin
      if (rw) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model[addr][i*8 +: 8] = data[i*8 +: 8];
        end
      end else begin
        exp_q.push_back({model[addr], tag});
      end
    end
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mem_rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_queue", 64'(exp_q.size()), 64'd0);
    check_eq("drain_pending", 64'(pending_reads), 64'd0);
    sync();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit rand_done;
  int rsp_before;

  initial begin
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_byteen = '0;
    mem_req_flags  = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    reset_n        = 1'b0;

    // Reset state
    #1;
    check_eq("rst_rsp_valid", 64'(mem_rsp_valid), 64'd0);
    check_eq("rst_req_ready", 64'(mem_req_ready), 64'd1);
    check_eq("rst_pending",   64'(pending_reads), 64'd0);
    check_eq("rst_rsp_data",  64'(mem_rsp_data),  64'd0);
    check_eq("rst_rsp_tag",   64'(mem_rsp_tag),   64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    sync();

    // Basic read with exact latency: fire at t, valid only at t+2
    do_req(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 8'h00);
    do_req(1'b0, 4'd3, 32'h0, 4'h0, 8'h05);
    @(negedge clk);
    check_eq("lat_t1_valid", 64'(mem_rsp_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_t2_valid", 64'(mem_rsp_valid), 64'd1);
    @(negedge clk);
    check_eq("lat_t3_valid", 64'(mem_rsp_valid), 64'd0);
    sync();

    // Partial and empty byte-enable writes
    do_req(1'b1, 4'd3, 32'h12345678, 4'h3, 8'h00);
    do_req(1'b0, 4'd3, 32'h0, 4'h0, 8'h11);
    do_req(1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 8'h00);
    do_req(1'b0, 4'd3, 32'h0, 4'h0, 8'h12);

    // Read immediately after write
    do_req(1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 8'h00);
    do_req(1'b0, 4'd7, 32'h0, 4'h0, 8'h21);
    wait_drain();

    // Fill every word, then back-to-back reads: steady state holds exactly
    // LATENCY reads in flight, i.e. one response per cycle.
    for (int a = 0; a < 16; a++) begin
      if (a != 3 && a != 7) do_req(1'b1, 4'(a), $urandom, 4'hF, 8'h00);
    end
    rsp_before = rsp_count;
    for (int k = 0; k < 8; k++) do_req(1'b0, 4'($urandom_range(0, 15)), 32'h0, 4'h0, 8'(8'h40 + k));
    @(negedge clk);
    check_eq("b2b_pending", 64'(pending_reads), 64'd2);
    sync();
    wait_drain();
    check_eq("b2b_rsp_count", 64'(rsp_count - rsp_before), 64'd8);

    // Random traffic with random response backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), 8'(8'h80 + k));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2;
          mem_rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    mem_rsp_ready = 1'b1;
    wait_drain();

    // Backpressure: 4 credits, 5th read blocked until a handshake
    mem_rsp_ready = 1'b0;
    for (int k = 1; k <= 4; k++) do_req(1'b0, 4'(k), 32'h0, 4'h0, 8'(k));
    @(negedge clk);
    check_eq("bp_ready_low", 64'(mem_req_ready), 64'd0);
    check_eq("bp_pending",   64'(pending_reads), 64'd4);
    check_eq("bp_head_tag",  64'(mem_rsp_tag),   64'd1);
    sync();
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 4'd9;
    mem_req_tag   = 8'd5;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_stall_ready", 64'(mem_req_ready), 64'd0);
      check_eq("bp_stall_tag",   64'(mem_rsp_tag),   64'd1);
      check_eq("bp_stall_data",  64'(mem_rsp_data),  64'(model[1]));
    end
    sync();
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_hs_cycle", 64'(mem_req_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_ready_restored", 64'(mem_req_ready), 64'd1);
    if (mem_req_ready) exp_q.push_back({model[9], 8'd5});
    sync();
    mem_req_valid = 1'b0;
    wait_drain();

    // Read fire and response handshake in the same cycle
    mem_rsp_ready = 1'b0;
    do_req(1'b0, 4'd2, 32'h0, 4'h0, 8'hA1);
    do_req(1'b0, 4'd4, 32'h0, 4'h0, 8'hA2);
    repeat (3) @(negedge clk);
    check_eq("sim_pending_before", 64'(pending_reads), 64'd2);
    sync();
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 4'd6;
    mem_req_tag   = 8'hA3;
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("sim_ready", 64'(mem_req_ready), 64'd1);
    if (mem_req_ready) exp_q.push_back({model[6], 8'hA3});
    sync();
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("sim_pending_after", 64'(pending_reads), 64'd2);
    check_eq("sim_head_tag",      64'(mem_rsp_tag),   64'hA2);
    sync();
    mem_rsp_ready = 1'b1;
    wait_drain();

    // Reset in the middle of outstanding reads
    mem_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) do_req(1'b0, 4'(k + 10), 32'h0, 4'h0, 8'(8'hC0 + k));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid",   64'(mem_rsp_valid), 64'd0);
    check_eq("mid_rst_pending", 64'(pending_reads), 64'd0);
    check_eq("mid_rst_ready",   64'(mem_req_ready), 64'd1);
    check_eq("mid_rst_data",    64'(mem_rsp_data),  64'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n       = 1'b1;
    mem_rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("post_rst_valid",   64'(mem_rsp_valid), 64'd0);
    check_eq("post_rst_ready",   64'(mem_req_ready), 64'd1);
    check_eq("post_rst_pending", 64'(pending_reads), 64'd0);
    sync();
    do_req(1'b0, 4'd3, 32'h0, 4'h0, 8'hD3);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
